// File: rtl/fwd_sel_stage.sv
// N-way operand selector (binary or priority one-hot select) followed by a
// pipeline register with stall, flush, valid tracking and a sticky select-error flag.
module fwd_sel_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int MODE   = 0,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        comb_out,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    sel_err
);

    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("fwd_sel_stage: NUM_IN must be in 2..16");
    end
    if (MODE == 0 && SEL_W < $clog2(NUM_IN)) begin : g_bad_bin_w
        $error("fwd_sel_stage: binary select narrower than clog2(NUM_IN)");
    end
    if (MODE == 1 && SEL_W != NUM_IN) begin : g_bad_hot_w
        $error("fwd_sel_stage: one-hot select width must equal NUM_IN");
    end
    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("fwd_sel_stage: MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] sel_word;
    logic             bad_sel;

    if (MODE == 0) begin : g_bin
        // Any code without a matching input falls back to input 0 and is flagged.
        always_comb begin
            sel_word = in_data[0 +: WIDTH];
            bad_sel  = 1'b1;
            for (int k = 0; k < NUM_IN; k++) begin
                if (sel == SEL_W'(k)) begin
                    sel_word = in_data[k*WIDTH +: WIDTH];
                    bad_sel  = 1'b0;
                end
            end
        end
    end else begin : g_hot
        // Lowest set bit wins; a second set bit marks the select as malformed.
        always_comb begin
            logic found;
            found    = 1'b0;
            sel_word = in_data[0 +: WIDTH];
            bad_sel  = 1'b0;
            for (int k = 0; k < NUM_IN; k++) begin
                if (sel[k]) begin
                    if (!found) begin
                        sel_word = in_data[k*WIDTH +: WIDTH];
                    end else begin
                        bad_sel = 1'b1;
                    end
                    found = 1'b1;
                end
            end
        end
    end

    assign comb_out = sel_word;

    // Valid semantics: in_valid qualifies the inputs of the current cycle only;
    // there is no ready. A load cycle (no stall, no flush) always captures the word,
    // and out_valid tells the next stage whether that captured word is meaningful.
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic             sel_err_d, sel_err_q;
    logic             load;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        load        = !flush && !stall;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else if (load) begin
            out_data_d  = sel_word;
            out_valid_d = in_valid;
        end
        if (err_clr) begin
            sel_err_d = 1'b0;
        end
        if (load && in_valid && bad_sel) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_fwd_sel_stage.sv
// Bench for fwd_sel_stage: a binary-select and a one-hot-select instance share
// the datapath controls; registered results go through an expected-value queue.
module tb_fwd_sel_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int EW     = WIDTH + 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              sel_b;
    logic [2:0]              sel_h;
    logic                    in_valid, stall, flush, err_clr;
    logic [WIDTH-1:0]        comb_b, data_b, comb_h, data_h;
    logic                    valid_b, err_b, valid_h, err_h;

    int checks = 0;
    int errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] hot_q[$];

    always #5 clk = ~clk;

    fwd_sel_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MODE(0), .SEL_W(2)) u_bin (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel_b),
        .in_valid(in_valid), .stall(stall), .flush(flush), .err_clr(err_clr),
        .comb_out(comb_b), .out_data(data_b), .out_valid(valid_b), .sel_err(err_b)
    );

    fwd_sel_stage #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .MODE(1), .SEL_W(3)) u_hot (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel_h),
        .in_valid(in_valid), .stall(stall), .flush(flush), .err_clr(err_clr),
        .comb_out(comb_h), .out_data(data_h), .out_valid(valid_h), .sel_err(err_h)
    );

    typedef struct packed {
        logic        rst;
        logic [1:0]  sel;
        logic        v;
        logic        st;
        logic        fl;
        logic        ec;
        logic [95:0] data;
        logic [31:0] e_comb;
        logic [31:0] e_data;
        logic        e_valid;
        logic        e_err;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic rst, input logic [1:0] sel, input logic v,
                                input logic st, input logic fl, input logic ec,
                                input logic [95:0] data, input logic [31:0] e_comb,
                                input logic [31:0] e_data, input logic e_valid,
                                input logic e_err);
        vec_t r;
        r.rst = rst; r.sel = sel; r.v = v; r.st = st; r.fl = fl; r.ec = ec;
        r.data = data; r.e_comb = e_comb; r.e_data = e_data;
        r.e_valid = e_valid; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply_bin(input vec_t v, input int idx);
        @(negedge clk);
        reset    = v.rst;
        sel_b    = v.sel;
        sel_h    = 3'b000;
        in_valid = v.v;
        stall    = v.st;
        flush    = v.fl;
        err_clr  = v.ec;
        in_data  = v.data;
        exp_q.push_back({v.e_err, v.e_valid, v.e_data});
        #1;
        chk($sformatf("bin_comb[%0d]", idx), {2'b00, comb_b}, {2'b00, v.e_comb});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("bin_q_empty[%0d]", idx), 1, 0);
        end else begin
            chk($sformatf("bin_reg[%0d]", idx), {err_b, valid_b, data_b}, exp_q.pop_front());
        end
    endtask

    task automatic apply_hot(input logic [2:0] s, input logic ec, input logic [31:0] e_comb,
                             input logic e_err, input logic [31:0] e_data, input string name);
        @(negedge clk);
        reset    = 1'b0;
        sel_b    = 2'd0;
        sel_h    = s;
        in_valid = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        err_clr  = ec;
        hot_q.push_back({e_err, 1'b1, e_data});
        #1;
        chk({"hot_comb_", name}, {2'b00, comb_h}, {2'b00, e_comb});
        @(posedge clk);
        #1;
        if (hot_q.size() == 0) begin
            chk({"hot_q_empty_", name}, 1, 0);
        end else begin
            chk({"hot_reg_", name}, {err_h, valid_h, data_h}, hot_q.pop_front());
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
        sel_b = 2'd0; sel_h = 3'b000;
        repeat (cycles) @(posedge clk);
        #1;
        chk("reset_bin", {err_b, valid_b, data_b}, '0);
        chk("reset_hot", {err_h, valid_h, data_h}, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [95:0] d0, d_dead, d_a, d_b, d_c;
        d0     = {32'h3, 32'h2, 32'h1};
        d_dead = {32'h3, 32'hDEAD, 32'h1};
        d_a    = {32'h5, 32'h6, 32'h7};
        d_b    = {32'h8, 32'h9, 32'hA};
        d_c    = {32'hB, 32'hC, 32'hD};

        vecs[0]  = mk(0, 2'd2, 1, 0, 0, 0, d0, 32'h3, 32'h3, 1, 0);
        vecs[1]  = mk(0, 2'd3, 1, 0, 0, 0, d0, 32'h1, 32'h1, 1, 1);
        for (int i = 2; i < 7; i++) vecs[i] = mk(0, 2'd0, 0, 0, 0, 0, d0, 32'h1, 32'h1, 0, 1);
        vecs[7]  = mk(0, 2'd0, 0, 0, 0, 1, d0, 32'h1, 32'h1, 0, 0);
        vecs[8]  = mk(0, 2'd3, 0, 0, 0, 0, d0, 32'h1, 32'h1, 0, 0);
        vecs[9]  = mk(0, 2'd1, 1, 0, 0, 0, d_dead, 32'hDEAD, 32'hDEAD, 1, 0);
        vecs[10] = mk(0, 2'd3, 1, 1, 0, 0, d_a, 32'h7, 32'hDEAD, 1, 0);
        vecs[11] = mk(0, 2'd0, 1, 1, 0, 0, d_b, 32'hA, 32'hDEAD, 1, 0);
        vecs[12] = mk(0, 2'd2, 1, 1, 0, 0, d_c, 32'hB, 32'hDEAD, 1, 0);
        vecs[13] = mk(0, 2'd2, 1, 1, 1, 0, d_c, 32'hB, 32'h0, 0, 0);
        vecs[14] = mk(0, 2'd3, 1, 0, 0, 0, d0, 32'h1, 32'h1, 1, 1);
        vecs[15] = mk(0, 2'd3, 1, 0, 0, 1, d0, 32'h1, 32'h1, 1, 1);
        vecs[16] = mk(0, 2'd3, 1, 0, 1, 0, d0, 32'h1, 32'h0, 0, 1);
        vecs[17] = mk(0, 2'd1, 1, 0, 0, 0, d0, 32'h2, 32'h2, 1, 1);
        vecs[18] = mk(1, 2'd0, 1, 1, 0, 0, d0, 32'h1, 32'h0, 0, 0);
        vecs[19] = mk(0, 2'd1, 1, 0, 0, 0, d0, 32'h2, 32'h2, 1, 0);

        reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
        sel_b = 2'd0; sel_h = 3'b000; in_data = d0;
        do_reset(2);

        for (int i = 0; i < 20; i++) apply_bin(vecs[i], i);

        // One-hot priority selects on the second instance.
        do_reset(1);
        in_data = d0;
        apply_hot(3'b000, 1'b0, 32'h1, 1'b0, 32'h1, "zero");
        apply_hot(3'b100, 1'b0, 32'h3, 1'b0, 32'h3, "bit2");
        apply_hot(3'b110, 1'b0, 32'h2, 1'b1, 32'h2, "multi_110");
        apply_hot(3'b010, 1'b1, 32'h2, 1'b0, 32'h2, "clr_bit1");
        apply_hot(3'b111, 1'b0, 32'h1, 1'b1, 32'h1, "multi_111");
        apply_hot(3'b011, 1'b0, 32'h1, 1'b1, 32'h1, "multi_011");

        // Random legal binary selects with fresh data each cycle.
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            int s;
            logic [95:0] rd;
            logic [31:0] w;
            rd = {$urandom(), $urandom(), $urandom()};
            s  = $urandom_range(0, 2);
            w  = rd[s*32 +: 32];
            apply_bin(mk(0, 2'(s), 1, 0, 0, 0, rd, w, w, 1, 0), 100 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
